alu32: RTL and testbench



---
 rtl/alu32.sv | 110 +++++++++++
 tb/tb_alu32.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu32.sv
`default_nettype none
// ============================================================================
//  Module   : alu32
//  Purpose  : 32-bit registered ALU for the execute stage. Seven operations
//             (AND, OR, ADD, AND-NOT, OR-NOT, SUB, SLT) selected by a 3-bit
//             function code; result and zero/carry/overflow flags are
//             captured in output registers, giving exactly one cycle of
//             latency and one operation per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module alu32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  F,
    output logic [31:0] Y,
    output logic        zero,
    output logic        carry,
    output logic        overflow
);

    // Function codes
    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_RSVD = 3'b011;
    localparam logic [2:0] c_OP_ANDN = 3'b100;
    localparam logic [2:0] c_OP_ORN  = 3'b101;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [2:0] c_OP_SLT  = 3'b111;

    // Shared adder: F[2] selects inverted B plus carry-in, turning the
    // adder into a subtractor for SUB and SLT.
    logic [31:0] w_bx;
    logic [32:0] w_sum;
    logic        w_cout;
    logic        w_ovf;
    logic        w_slt;

    assign w_bx   = F[2] ? ~B : B;
    assign w_sum  = {1'b0, A} + {1'b0, w_bx} + {32'd0, F[2]};
    assign w_cout = w_sum[32];
    // Signed overflow: operands agree in sign but the sum does not.
    assign w_ovf  = (A[31] == w_bx[31]) && (w_sum[31] != A[31]);
    // Sign of the difference corrected for overflow gives a true signed compare.
    assign w_slt  = w_sum[31] ^ w_ovf;

    logic [31:0] w_result;
    logic        w_carry;
    logic        w_overflow;

    // Operation decode; anything not listed (reserved code or unknown F)
    // falls to the all-zero result with flags cleared.
    always_comb begin
        w_result   = 32'd0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (F)
            c_OP_AND:  w_result = A & B;
            c_OP_OR:   w_result = A | B;
            c_OP_ADD: begin
                w_result   = w_sum[31:0];
                w_carry    = w_cout;
                w_overflow = w_ovf;
            end
            c_OP_RSVD: w_result = 32'd0;
            c_OP_ANDN: w_result = A & ~B;
            c_OP_ORN:  w_result = A | ~B;
            c_OP_SUB: begin
                w_result   = w_sum[31:0];
                w_carry    = w_cout;
                w_overflow = w_ovf;
            end
            c_OP_SLT:  w_result = {31'd0, w_slt};
            default: begin
                w_result   = 32'd0;
                w_carry    = 1'b0;
                w_overflow = 1'b0;
            end
        endcase
    end

    logic [31:0] r_y;
    logic        r_zero;
    logic        r_carry;
    logic        r_overflow;

    // Output register stage; reset forces Y=0 with zero set to match.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y        <= 32'd0;
            r_zero     <= 1'b1;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_y        <= w_result;
            r_zero     <= (w_result == 32'd0);
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
        end
    end

    assign Y        = r_y;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu32
//  Purpose  : Directed self-checking bench for alu32 with hand-computed
//             expected results and flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu32;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  F;
    logic [31:0] Y;
    logic        zero;
    logic        carry;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    alu32 u_dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .F        (F),
        .Y        (Y),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive operands, clock once, settle just after the edge.
    task automatic step(input logic rst_i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        reset = rst_i;
        A     = a;
        B     = b;
        F     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] y, input logic z,
                             input logic c, input logic o);
        check({tag, ".Y"}, Y, y);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        check({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
        check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, o});
    endtask

    // Sweep table for A=64, B=128
    logic [2:0]  sw_f [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [31:0] sw_y [7] = '{32'd0, 32'd192, 32'd192, 32'd64, 32'hFFFF_FF7F,
                              32'hFFFF_FFC0, 32'd1};

    initial begin
        reset = 1'b1;
        A     = 32'hFFFF_FFFF;
        B     = 32'd2;
        F     = 3'b010;

        // Reset held two cycles with inputs that would otherwise give Y=1, carry=1
        step(1'b1, 32'hFFFF_FFFF, 32'd2, 3'b010);
        step(1'b1, 32'hFFFF_FFFF, 32'd2, 3'b010);
        check_all("reset", 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'hFFFF_FFFF, 32'd2, 3'b010);
        check_all("post_reset_add", 32'd1, 1'b0, 1'b1, 1'b0);

        // Operation sweep
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 32'd64, 32'd128, sw_f[i]);
            check($sformatf("sweep%0d.Y", i), Y, sw_y[i]);
            check($sformatf("sweep%0d.zero", i), {31'd0, zero}, {31'd0, (i == 0)});
        end
        // SUB 64-128 borrows: carry=0; last step was SLT so re-run SUB for flags
        step(1'b0, 32'd64, 32'd128, 3'b110);
        check_all("sub_borrow", 32'hFFFF_FFC0, 1'b0, 1'b0, 1'b0);

        // Arithmetic flags
        step(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010);
        check_all("add_wrap", 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010);
        check_all("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd5, 32'd5, 3'b110);
        check_all("sub_eq", 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h8000_0000, 32'd1, 3'b110);
        check_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

        // SLT across overflow
        step(1'b0, 32'h8000_0000, 32'd1, 3'b111);
        check_all("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111);
        check_all("slt_pos", 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b111);
        check_all("slt_eq", 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b111);
        check_all("slt_negneg", 32'd1, 1'b0, 1'b0, 1'b0);

        // Reserved code
        step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
        check_all("reserved", 32'd0, 1'b1, 1'b0, 1'b0);

        // Latency: output holds before the edge, updates after it
        step(1'b0, 32'h0000_00F0, 32'h0000_00FF, 3'b001);
        check("lat_or", Y, 32'h0000_00FF);
        A = 32'h0000_00F0; B = 32'h0000_00FF; F = 3'b000;
        #1;
        check("lat_hold", Y, 32'h0000_00FF);
        @(posedge clk); #1;
        check("lat_and", Y, 32'h0000_00F0);

        // Back-to-back with a single-cycle reset in the middle
        step(1'b0, 32'd64, 32'd128, 3'b010);
        check("pipe_add", Y, 32'd192);
        step(1'b1, 32'd64, 32'd128, 3'b101);
        check_all("pipe_reset", 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd64, 32'd128, 3'b110);
        check("pipe_sub", Y, 32'hFFFF_FFC0);
        step(1'b0, 32'd64, 32'd128, 3'b100);
        check("pipe_andn", Y, 32'd64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
